// File: rtl/multi_target_game.sv
// multi_target_game: timed target-hitting game core.
// A blade moved once per frame by direction inputs scores one point per
// target it touched during that frame; a round lasts GAME_SECONDS seconds.
// Optional build macro: MULTI_TARGET_COMBO_EN doubles the points of any frame
// that hits two or more targets (score still saturates).
module multi_target_game #(
    parameter int NUM_TARGETS  = 4,
    parameter int BLADE_SPEED  = 4,
    parameter int GAME_SECONDS = 30,
    parameter int SCORE_W      = 8,
    parameter int CLK_HZ       = 65000000
) (
    input  logic                   vclock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   up,
    input  logic                   down,
    input  logic                   left,
    input  logic                   right,
    input  logic                   blade_occupied,
    input  logic [NUM_TARGETS-1:0] target_occupied,
    input  logic [10:0]            hcount,
    input  logic [9:0]             vcount,
    output logic [10:0]            blade_x,
    output logic [9:0]             blade_y,
    output logic [NUM_TARGETS-1:0] target_en,
    output logic [NUM_TARGETS-1:0] respawn,
    output logic [5:0]             countdown,
    output logic [SCORE_W-1:0]     score,
    output logic [1:0]             state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_OVER = 2'b10
    } state_t;

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int SW = SCORE_W + 6;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_t                 cur, nxt;
    logic [PW-1:0]          presc;
    logic [NUM_TARGETS-1:0] flags;
    logic [NUM_TARGETS-1:0] new_hits;
    logic                   play, launch, frame_tick, sec_wrap;
    logic [3:0]             hit_cnt;
    logic [4:0]             add;
    logic [SW-1:0]          sum;
    logic [SCORE_W-1:0]     score_n;
    logic [10:0]            blade_x_n;
    logic [9:0]             blade_y_n;
    int                     bx_i, by_i;

    assign play       = (cur == S_PLAY);
    assign launch     = !play && start;
    assign frame_tick = (hcount == 11'd1030) && (vcount == 10'd800);
    assign sec_wrap   = play && (presc == PW'(CLK_HZ - 1));
    assign new_hits   = {NUM_TARGETS{blade_occupied}} & target_occupied & target_en;

    // FSM state register
    always_ff @(posedge vclock or posedge reset) begin
        if (reset) cur <= S_IDLE;
        else       cur <= nxt;
    end

    // FSM next state: start launches a round, the last second wrap ends it
    always_comb begin
        nxt = cur;
        case (cur)
            S_IDLE, S_OVER: if (start) nxt = S_PLAY;
            S_PLAY:         if (sec_wrap && countdown == 6'd1) nxt = S_OVER;
            default:        nxt = S_IDLE;
        endcase
    end

    // FSM outputs: targets are only shown while playing
    always_comb begin
        target_en = play ? '1 : '0;
        state     = cur;
    end

    // Frame scoring and blade motion, computed from the current flags/position
    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < NUM_TARGETS; i++) hit_cnt = hit_cnt + 4'(flags[i]);
`ifdef MULTI_TARGET_COMBO_EN
        add = (hit_cnt >= 4'd2) ? {hit_cnt, 1'b0} : {1'b0, hit_cnt};
`else
        add = {1'b0, hit_cnt};
`endif
        sum     = SW'(score) + SW'(add);
        score_n = (sum > SW'(SCORE_MAX)) ? SCORE_MAX : sum[SCORE_W-1:0];

        // opposite requests cancel; moves past an edge stop at the edge
        bx_i = int'(blade_x);
        by_i = int'(blade_y);
        if (left && !right)  bx_i = bx_i - BLADE_SPEED;
        if (right && !left)  bx_i = bx_i + BLADE_SPEED;
        if (up && !down)     by_i = by_i - BLADE_SPEED;
        if (down && !up)     by_i = by_i + BLADE_SPEED;
        if (bx_i < 0)        bx_i = 0;
        if (bx_i > 1023)     bx_i = 1023;
        if (by_i < 0)        by_i = 0;
        if (by_i > 767)      by_i = 767;
        blade_x_n = 11'(bx_i);
        blade_y_n = 10'(by_i);
    end

    // Round datapath: prescaler, countdown, hit flags, score, blade, respawn
    always_ff @(posedge vclock or posedge reset) begin
        if (reset) begin
            presc     <= '0;
            countdown <= 6'(GAME_SECONDS);
            score     <= '0;
            blade_x   <= 11'd480;
            blade_y   <= 10'd280;
            flags     <= '0;
            respawn   <= '0;
        end else begin
            respawn <= '0;
            if (launch) begin
                presc     <= '0;
                countdown <= 6'(GAME_SECONDS);
                score     <= '0;
                blade_x   <= 11'd480;
                blade_y   <= 10'd280;
                flags     <= '0;
                respawn   <= '1;
            end else if (play) begin
                presc <= sec_wrap ? '0 : presc + 1'b1;
                if (sec_wrap) countdown <= countdown - 6'd1;
                if (frame_tick) begin
                    // hits landing on the tick cycle belong to the next frame
                    score   <= score_n;
                    respawn <= flags;
                    flags   <= new_hits;
                    blade_x <= blade_x_n;
                    blade_y <= blade_y_n;
                end else begin
                    flags <= flags | new_hits;
                end
            end else begin
                flags <= '0;
            end
        end
    end

endmodule

// File: doc/multi_target_game.md
MULTI_TARGET_GAME -- requirements
Module: multi_target_game

Interface
REQ-001 Parameter NUM_TARGETS, 4, number of independent hittable targets (1..8).
REQ-002 Parameter BLADE_SPEED, 4, pixels moved per frame per direction input.
REQ-003 Parameter GAME_SECONDS, 30, round length in seconds (1..63).
REQ-004 Parameter SCORE_W, 8, score width in bits.
REQ-005 Parameter CLK_HZ, 65000000, vclock cycles per second.
REQ-006 vclock  in  1  65MHz pixel clock; the block's only clock.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  level; starts or restarts a round.
REQ-009 up, down, left, right  in  1 each  blade direction requests.
REQ-010 blade_occupied  in  1  blade renderer covers current pixel.
REQ-011 target_occupied  in  NUM_TARGETS  per-target renderer covers current pixel.
REQ-012 hcount  in  11, vcount  in  10  current XVGA pixel.
REQ-013 blade_x  out  11, blade_y  out  10  blade handle-top position.
REQ-014 target_en  out  NUM_TARGETS  per-target display enable.
REQ-015 respawn  out  NUM_TARGETS  one-cycle pulse; target takes a new random position.
REQ-016 countdown  out  6  seconds remaining.
REQ-017 score  out  SCORE_W  points this round.
REQ-018 state  out  2  00 IDLE, 01 PLAY, 10 OVER.

Function
REQ-019 Frame tick asserts for exactly one cycle when hcount==1030 and vcount==800.
REQ-020 The FSM has three states: IDLE, PLAY, OVER.
REQ-021 IDLE or OVER with start=1 -> PLAY next cycle; on entry: score=0, countdown=GAME_SECONDS, blade=(480,280), prescaler=0, respawn=all ones for one cycle.
REQ-022 start while in PLAY is ignored.
REQ-023 target_en is all ones in PLAY and all zeros in IDLE and OVER.
REQ-024 A CLK_HZ-cycle prescaler runs only in PLAY; each wrap decrements countdown by 1.
REQ-025 The wrap that takes countdown from 1 to 0 moves the FSM to OVER on the same edge.
REQ-026 In PLAY, a per-target sticky hit flag sets on any cycle with blade_occupied & target_occupied[i] & target_en[i].
REQ-027 At frame tick in PLAY: score += popcount(hit flags); respawn pulses for flagged targets; all flags clear.
REQ-028 Score saturates at 2^SCORE_W-1 and never wraps.
REQ-029 Flags that set on the frame-tick cycle itself are counted in the next frame.
REQ-030 At frame tick in PLAY, blade_y moves -BLADE_SPEED on up and +BLADE_SPEED on down; up and down together leave it unchanged; left/right apply the same rule to blade_x.
REQ-031 Blade_x clamps to 0..1023 and blade_y to 0..767; a move past a limit stops at the limit, with no wrap-around.
REQ-032 If frame tick and the final second wrap coincide, that frame's score and move are applied before entering OVER.
REQ-033 In OVER, score and countdown hold and hit flags are cleared.

Reset
REQ-034 On reset=1, independent of vclock: state=IDLE, score=0, countdown=GAME_SECONDS, blade=(480,280), target_en=0, respawn=0, hit flags=0, prescaler=0.
REQ-035 Reset asserted mid-round abandons the round with no score update and no respawn pulse; after release the block waits in IDLE for start.

Configuration
REQ-036 Macro MULTI_TARGET_COMBO_EN is defined: a frame tick with 2 or more flags set adds 2*popcount, still saturating.
REQ-037 Macro MULTI_TARGET_COMBO_EN is undefined: every frame tick adds popcount only; there is no combo logic.

Verification
REQ-038 Scenario: reset, start pulse -> state=01, countdown=30, score=0, respawn=4'b1111 for one cycle.
REQ-039 Scenario: in PLAY, overlap targets 0 and 2 for 3 cycles in one frame -> at frame tick score +2 (+4 with COMBO_EN), respawn=4'b0101 for one cycle.
REQ-040 Scenario: blade_x=2, left held one frame -> blade_x=0; up and down held together -> blade_y unchanged.
REQ-041 Scenario: CLK_HZ=100, GAME_SECONDS=2 -> countdown reaches 0 after 200 PLAY cycles, state=10, target_en=0; start -> PLAY with score=0.
REQ-042 Scenario: SCORE_W=2, score=3, one more hit -> score stays 3.
REQ-043 Scenario: reset pulse between vclock edges mid-round -> outputs reach reset values immediately; no respawn pulse follows.
